// File: rtl/jt12_mix_acc.sv
// jt12_mix_acc: stereo output accumulator for the FM/PCM sound path.
// FM operator slots are summed under algorithm/pan gating. Each auxiliary PCM
// source is added once per frame in an idle cen cycle. Saturated left/right
// samples are produced on every frame boundary.
module jt12_mix_acc #(
    parameter int WIN    = 14,
    parameter int WOUT   = 16,
    parameter int NAUX   = 2,
    parameter int AUXW   = 16,
    parameter int ACCW   = 20,
    parameter int FM_SHR = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic                   clk_en,
    input  logic [WIN-1:0]         op_result,
    input  logic [1:0]             rl,
    input  logic [2:0]             alg,
    input  logic                   s1_enters,
    input  logic                   s2_enters,
    input  logic                   s3_enters,
    input  logic                   s4_enters,
    input  logic                   zero,
    input  logic [NAUX*AUXW-1:0]   aux_l,
    input  logic [NAUX*AUXW-1:0]   aux_r,
    input  logic [NAUX-1:0]        aux_vld,
    input  logic [NAUX*4-1:0]      aux_gain,
    input  logic                   clr_flags,
    output logic [WOUT-1:0]        left,
    output logic [WOUT-1:0]        right,
    output logic                   sample,
    output logic                   clip,
    output logic                   aux_ovf
);

    // Output range expressed at accumulator width
    localparam logic signed [ACCW-1:0] L_MAX = {{(ACCW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
    localparam logic signed [ACCW-1:0] L_MIN = {{(ACCW-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

    // Clamp an accumulator value into the output sample range
    function automatic logic [WOUT-1:0] sat_out(input logic signed [ACCW-1:0] v);
        if (v > L_MAX) begin
            sat_out = L_MAX[WOUT-1:0];
        end else if (v < L_MIN) begin
            sat_out = L_MIN[WOUT-1:0];
        end else begin
            sat_out = v[WOUT-1:0];
        end
    endfunction

    // True when sat_out would have to clamp the value
    function automatic logic is_clamped(input logic signed [ACCW-1:0] v);
        is_clamped = (v > L_MAX) || (v < L_MIN);
    endfunction

    // Gain-scaled aux sample: (sext(s) * g) >>> 2, gain 4 = unity
    function automatic logic signed [ACCW-1:0] aux_term(input logic [AUXW-1:0] s,
                                                        input logic [3:0]      g);
        logic signed [ACCW+4:0] prod;
        prod = $signed({{(ACCW+5-AUXW){s[AUXW-1]}}, s}) *
               $signed({{(ACCW+1){1'b0}}, g});
        aux_term = prod[ACCW+1:2];
    endfunction

    logic [AUXW-1:0]        r_latch_l [NAUX];
    logic [AUXW-1:0]        r_latch_r [NAUX];
    logic [NAUX-1:0]        r_done;
    logic signed [ACCW-1:0] r_acc_l;
    logic signed [ACCW-1:0] r_acc_r;

    logic                   w_sum_en;
    logic signed [ACCW-1:0] w_fm;
    logic signed [ACCW-1:0] w_fm_l;
    logic signed [ACCW-1:0] w_fm_r;
    logic                   w_sel_vld;
    logic [NAUX-1:0]        w_sel_mask;
    logic signed [ACCW-1:0] w_aux_l;
    logic signed [ACCW-1:0] w_aux_r;
    logic                   w_frame;
    logic                   w_clip_set;
    logic                   w_ovf_set;

    // Decide whether the current operator slot feeds the output for this algorithm
    always_comb begin
        w_sum_en = 1'b0;
        case (alg)
            3'd0, 3'd1, 3'd2, 3'd3: w_sum_en = s4_enters;
            3'd4:                   w_sum_en = s2_enters | s4_enters;
            3'd5, 3'd6:             w_sum_en = ~s1_enters;
            3'd7:                   w_sum_en = 1'b1;
            default:                w_sum_en = 1'b0;
        endcase
    end

    assign w_fm   = $signed({{(ACCW-WIN){op_result[WIN-1]}}, op_result}) >>> FM_SHR;
    assign w_fm_l = (w_sum_en && rl[1]) ? w_fm : '0;
    assign w_fm_r = (w_sum_en && rl[0]) ? w_fm : '0;

    // Pick the lowest aux source not yet injected this frame and form its terms
    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_mask = '0;
        w_aux_l    = '0;
        w_aux_r    = '0;
        for (int i = NAUX - 1; i >= 0; i--) begin
            if (!r_done[i]) begin
                w_sel_vld  = 1'b1;
                w_sel_mask = '0;
                w_sel_mask[i] = 1'b1;
                w_aux_l    = aux_term(r_latch_l[i], aux_gain[i*4 +: 4]);
                w_aux_r    = aux_term(r_latch_r[i], aux_gain[i*4 +: 4]);
            end else begin
                w_sel_mask = w_sel_mask;
            end
        end
    end

    assign w_frame    = cen & clk_en & zero;
    assign w_clip_set = w_frame & (is_clamped(r_acc_l) | is_clamped(r_acc_r));
    assign w_ovf_set  = w_frame & ~(&r_done);

    // Capture aux samples on their strobes; sources are free-running so this ignores cen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NAUX; i++) begin
                r_latch_l[i] <= '0;
                r_latch_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NAUX; i++) begin
                if (aux_vld[i]) begin
                    r_latch_l[i] <= aux_l[i*AUXW +: AUXW];
                    r_latch_r[i] <= aux_r[i*AUXW +: AUXW];
                end
            end
        end
    end

    // Accumulate FM slots and aux injections; publish saturated samples on frame cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_done  <= '0;
            left    <= '0;
            right   <= '0;
        end else if (cen) begin
            if (clk_en) begin
                if (zero) begin
                    left    <= sat_out(r_acc_l);
                    right   <= sat_out(r_acc_r);
                    r_acc_l <= w_fm_l;
                    r_acc_r <= w_fm_r;
                    r_done  <= '0;
                end else begin
                    r_acc_l <= r_acc_l + w_fm_l;
                    r_acc_r <= r_acc_r + w_fm_r;
                end
            end else if (w_sel_vld) begin
                r_acc_l <= r_acc_l + w_aux_l;
                r_acc_r <= r_acc_r + w_aux_r;
                r_done  <= r_done | w_sel_mask;
            end
        end
    end

    // Sample strobe follows the frame cycle by one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= 1'b0;
        end else begin
            sample <= w_frame;
        end
    end

    // Sticky status flags; a set on the same clock as a clear takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip    <= 1'b0;
            aux_ovf <= 1'b0;
        end else begin
            if (w_clip_set) begin
                clip <= 1'b1;
            end else if (clr_flags) begin
                clip <= 1'b0;
            end
            if (w_ovf_set) begin
                aux_ovf <= 1'b1;
            end else if (clr_flags) begin
                aux_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jt12_mix_acc.sv
// Directed testbench for jt12_mix_acc with hand-computed expected samples.
module tb_jt12_mix_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic        clk_en;
    logic [13:0] op_result;
    logic [1:0]  rl;
    logic [2:0]  alg;
    logic        s1_enters, s2_enters, s3_enters, s4_enters;
    logic        zero;
    logic [31:0] aux_l;
    logic [31:0] aux_r;
    logic [1:0]  aux_vld;
    logic [7:0]  aux_gain;
    logic        clr_flags;
    logic [15:0] left;
    logic [15:0] right;
    logic        sample;
    logic        clip;
    logic        aux_ovf;

    int n_checks = 0;
    int n_errors = 0;

    jt12_mix_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .clk_en    (clk_en),
        .op_result (op_result),
        .rl        (rl),
        .alg       (alg),
        .s1_enters (s1_enters),
        .s2_enters (s2_enters),
        .s3_enters (s3_enters),
        .s4_enters (s4_enters),
        .zero      (zero),
        .aux_l     (aux_l),
        .aux_r     (aux_r),
        .aux_vld   (aux_vld),
        .aux_gain  (aux_gain),
        .clr_flags (clr_flags),
        .left      (left),
        .right     (right),
        .sample    (sample),
        .clip      (clip),
        .aux_ovf   (aux_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given controls; s = {s4,s3,s2,s1}. Strobes drop afterwards.
    task automatic cyc(input logic ce, input logic en, input logic z, input int op,
                       input logic [2:0] a, input logic [1:0] r, input logic [3:0] s);
        cen       = ce;
        clk_en    = en;
        zero      = z;
        op_result = op[13:0];
        alg       = a;
        rl        = r;
        {s4_enters, s3_enters, s2_enters, s1_enters} = s;
        @(posedge clk);
        #1;
        aux_vld   = 2'b00;
        clr_flags = 1'b0;
    endtask

    task automatic fm(input int op, input logic [2:0] a, input logic [1:0] r,
                      input logic [3:0] s);
        cyc(1'b1, 1'b1, 1'b0, op, a, r, s);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 0, 3'd0, 2'b00, 4'b0000);
    endtask

    task automatic frame();
        cyc(1'b1, 1'b1, 1'b1, 0, 3'd0, 2'b00, 4'b0000);
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b0; clk_en = 1'b0; zero = 1'b0;
        op_result = 14'd0; rl = 2'b00; alg = 3'd0;
        s1_enters = 1'b0; s2_enters = 1'b0; s3_enters = 1'b0; s4_enters = 1'b0;
        aux_l = 32'd0; aux_r = 32'd0; aux_vld = 2'b00; aux_gain = 8'd0; clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_left",    $signed(left), 0);
        chk("rst_right",   $signed(right), 0);
        chk("rst_sample",  sample, 0);
        chk("rst_clip",    clip, 0);
        chk("rst_aux_ovf", aux_ovf, 0);
        rst_n = 1'b1;

        // Four FM slots of 100 (>>>1 = 50 each), both sides, alg 7
        for (int k = 0; k < 4; k++) fm(100, 3'd7, 2'b11, 4'b0001 << k);
        idle(); idle();
        frame();
        chk("t1_left",    $signed(left), 200);
        chk("t1_right",   $signed(right), 200);
        chk("t1_sample",  sample, 1);
        chk("t1_aux_ovf", aux_ovf, 0);
        idle();
        chk("t1_sample_low", sample, 0);
        chk("t1_hold",       $signed(left), 200);
        // cen low: a frame-looking cycle must do nothing
        cyc(1'b0, 1'b1, 1'b1, 100, 3'd7, 2'b11, 4'b1111);
        chk("cen0_left",   $signed(left), 200);
        chk("cen0_sample", sample, 0);

        // alg 0, left only, -64 counted only on the s4 slot
        fm(-64, 3'd0, 2'b10, 4'b0001);
        fm(-64, 3'd0, 2'b10, 4'b0010);
        fm(-64, 3'd0, 2'b10, 4'b0100);
        fm(-64, 3'd0, 2'b10, 4'b1000);
        idle(); idle();
        frame();
        chk("t2_left",  $signed(left), -32);
        chk("t2_right", $signed(right), 0);

        // Aux: L 1000*4/4 + -500*8/4 = 0 ; R 1000 + -200*8/4 = 600
        aux_l    = {-16'sd500, 16'sd1000};
        aux_r    = {-16'sd200, 16'sd1000};
        aux_gain = {4'd8, 4'd4};
        aux_vld  = 2'b11;
        fm(0, 3'd7, 2'b00, 4'b0000);
        idle(); idle();
        frame();
        chk("t3_left",    $signed(left), 0);
        chk("t3_right",   $signed(right), 600);
        chk("t3_aux_ovf", aux_ovf, 0);

        // Saturation: +/-30000 * 8 / 4 = +/-60000, source 1 muted
        aux_l    = {16'sd0, 16'sd30000};
        aux_r    = {16'sd0, -16'sd30000};
        aux_gain = {4'd0, 4'd8};
        aux_vld  = 2'b01;
        fm(0, 3'd7, 2'b00, 4'b0000);
        idle(); idle();
        frame();
        chk("t4_left",  $signed(left), 32767);
        chk("t4_right", $signed(right), -32768);
        chk("t4_clip",  clip, 1);
        clr_flags = 1'b1;
        fm(0, 3'd7, 2'b00, 4'b0000);
        chk("t4_clip_clr", clip, 0);

        // Single idle cycle: only source 0 reaches the frame
        aux_l    = {-16'sd500, 16'sd1000};
        aux_r    = {16'sd0, -16'sd2000};
        aux_gain = {4'd8, 4'd4};
        aux_vld  = 2'b11;
        fm(0, 3'd7, 2'b00, 4'b0000);
        idle();
        frame();
        chk("t5_left",    $signed(left), 1000);
        chk("t5_right",   $signed(right), -2000);
        chk("t5_aux_ovf", aux_ovf, 1);
        chk("t5_clip",    clip, 0);

        // Reset in the middle of a frame with a nonzero accumulator
        fm(100, 3'd7, 2'b11, 4'b0001);
        fm(100, 3'd7, 2'b11, 4'b0010);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_left",    $signed(left), 0);
        chk("t6_rst_aux_ovf", aux_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); idle();
        frame();
        chk("t6_left",    $signed(left), 0);
        chk("t6_right",   $signed(right), 0);
        chk("t6_clip",    clip, 0);
        chk("t6_aux_ovf", aux_ovf, 0);
        chk("t6_sample",  sample, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
